fwd_arb: RTL and testbench

Forwarder-side arbiter for the parallel packet-filter cores. It is the read-out counterpart of the snooper arbiter. It picks one core that holds an accepted packet, using round-robin order, and acknowledges that core. It then routes the forwarder's reads to that core's packet memory and the read data back. When the forwarder signals done, it tells the core and releases the grant.

---
 rtl/fwd_arb_pkg.sv | 13 +
 rtl/fwd_arb_rr_pick.sv | 29 ++
 rtl/fwd_arb.sv | 146 ++++++++++++++
 tb/tb_fwd_arb.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_arb_pkg.sv
// Shared definitions for the forwarder/snooper arbiters: FSM encoding and default widths.
package fwd_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int PACKMEM_ADDR_WIDTH = 8;
  localparam int PACKMEM_DATA_WIDTH = 64;
  localparam int PLEN_SIZE          = 32;

endpackage

// File: rtl/fwd_arb_rr_pick.sv
// Combinational round-robin priority encoder: first set req bit at or above ptr, modulo N.
module fwd_arb_rr_pick #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          any
);
  import fwd_arb_pkg::*;

  logic [PW-1:0] pos_s;

  // Walk offsets from farthest to nearest so the requester closest to ptr is written last.
  always_comb begin
    gnt   = {N{1'b0}};
    idx   = {PW{1'b0}};
    pos_s = {PW{1'b0}};
    any   = |req;
    for (int k = N - 1; k >= 0; k--) begin
      pos_s = PW'((int'(ptr) + k) % N);
      gnt   = req[pos_s] ? ({{(N-1){1'b0}}, 1'b1} << pos_s) : gnt;
      idx   = req[pos_s] ? pos_s : idx;
    end
  end

endmodule

// File: rtl/fwd_arb.sv
// Forwarder-side round-robin arbiter over the packet-filter cores' packet memories.
// Optional: define FWD_ARB_RD_PIPE_EN to register rd_data/rd_data_vld after the mux.
module fwd_arb #(
  parameter int PACKMEM_ADDR_WIDTH = fwd_arb_pkg::PACKMEM_ADDR_WIDTH,
  parameter int PACKMEM_DATA_WIDTH = fwd_arb_pkg::PACKMEM_DATA_WIDTH,
  parameter int PLEN_SIZE          = fwd_arb_pkg::PLEN_SIZE,
  parameter int N                  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [PACKMEM_ADDR_WIDTH-1:0]   addr,
  input  logic                            rd_en,
  input  logic                            done,
  output logic                            rdy,
  output logic [PACKMEM_DATA_WIDTH-1:0]   rd_data,
  output logic                            rd_data_vld,
  output logic [PLEN_SIZE-1:0]            len,
  input  logic [N-1:0]                    rdy_for_fwd,
  input  logic [N*PLEN_SIZE-1:0]          fwd_len,
  input  logic [N*PACKMEM_DATA_WIDTH-1:0] fwd_rd_data,
  input  logic [N-1:0]                    fwd_rd_data_vld,
  output logic [PACKMEM_ADDR_WIDTH-1:0]   fwd_addr,
  output logic [N-1:0]                    fwd_rd_en,
  output logic [N-1:0]                    fwd_done,
  output logic [N-1:0]                    rdy_for_fwd_ack
);
  import fwd_arb_pkg::*;

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  state_t                        state_r;
  logic [N-1:0]                  sel_r;
  logic [PW-1:0]                 sel_idx_r;
  logic [PW-1:0]                 rr_ptr_r;
  logic [PLEN_SIZE-1:0]          len_r;
  logic [N-1:0]                  ack_r;
  logic [N-1:0]                  fwd_done_r;
  logic                          rdy_r;

  logic [N-1:0]                  pick_gnt_s;
  logic [PW-1:0]                 pick_idx_s;
  logic                          pick_any_s;
  logic [PLEN_SIZE-1:0]          pick_len_s;
  logic [PACKMEM_DATA_WIDTH-1:0] mux_data_s;
  logic                          mux_vld_s;
  logic [PW-1:0]                 next_ptr_s;

  fwd_arb_rr_pick #(.N(N), .PW(PW)) u_rr_pick (
    .req (rdy_for_fwd),
    .ptr (rr_ptr_r),
    .gnt (pick_gnt_s),
    .idx (pick_idx_s),
    .any (pick_any_s)
  );

  // Length of the core that would be granted at this edge.
  always_comb begin
    pick_len_s = {PLEN_SIZE{1'b0}};
    for (int i = 0; i < N; i++) begin
      pick_len_s = pick_len_s | ({PLEN_SIZE{pick_gnt_s[i]}} & fwd_len[i*PLEN_SIZE +: PLEN_SIZE]);
    end
  end

  // Read-return mux; sel_r persists through IDLE so late data from the last core still lands.
  always_comb begin
    mux_data_s = {PACKMEM_DATA_WIDTH{1'b0}};
    for (int i = 0; i < N; i++) begin
      mux_data_s = mux_data_s |
                   ({PACKMEM_DATA_WIDTH{sel_r[i]}} & fwd_rd_data[i*PACKMEM_DATA_WIDTH +: PACKMEM_DATA_WIDTH]);
    end
    mux_vld_s = |(sel_r & fwd_rd_data_vld);
  end

  assign next_ptr_s = (sel_idx_r == PW'(N - 1)) ? {PW{1'b0}} : sel_idx_r + {{(PW-1){1'b0}}, 1'b1};

  // Grant/release FSM with one-cycle ack and done pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      sel_r      <= {N{1'b0}};
      sel_idx_r  <= {PW{1'b0}};
      rr_ptr_r   <= {PW{1'b0}};
      len_r      <= {PLEN_SIZE{1'b0}};
      ack_r      <= {N{1'b0}};
      fwd_done_r <= {N{1'b0}};
      rdy_r      <= 1'b0;
    end else begin
      ack_r      <= {N{1'b0}};
      fwd_done_r <= {N{1'b0}};
      case (state_r)
        IDLE: begin
          if (pick_any_s) begin
            state_r   <= BUSY;
            sel_r     <= pick_gnt_s;
            sel_idx_r <= pick_idx_s;
            len_r     <= pick_len_s;
            ack_r     <= pick_gnt_s;
            rdy_r     <= 1'b1;
          end
        end
        BUSY: begin
          if (done) begin
            state_r    <= IDLE;
            rdy_r      <= 1'b0;
            fwd_done_r <= sel_r;
            rr_ptr_r   <= next_ptr_s;
          end
        end
        default: begin
          state_r <= IDLE;
          rdy_r   <= 1'b0;
        end
      endcase
    end
  end

  assign rdy             = rdy_r;
  assign len             = len_r;
  assign rdy_for_fwd_ack = ack_r;
  assign fwd_done        = fwd_done_r;
  assign fwd_addr        = addr;
  assign fwd_rd_en       = (rdy_r & rd_en) ? sel_r : {N{1'b0}};

`ifdef FWD_ARB_RD_PIPE_EN
  logic [PACKMEM_DATA_WIDTH-1:0] rd_data_r;
  logic                          rd_data_vld_r;

  // Register the muxed read return.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_r     <= {PACKMEM_DATA_WIDTH{1'b0}};
      rd_data_vld_r <= 1'b0;
    end else begin
      rd_data_r     <= mux_data_s;
      rd_data_vld_r <= mux_vld_s;
    end
  end

  assign rd_data     = rd_data_r;
  assign rd_data_vld = rd_data_vld_r;
`else
  assign rd_data     = mux_data_s;
  assign rd_data_vld = mux_vld_s;
`endif

endmodule

// File: tb/tb_fwd_arb.sv
// Self-checking bench for fwd_arb: scenario tasks plus a read-data scoreboard fed by a core model.
module tb_fwd_arb;
  localparam int AW = 8;
  localparam int DW = 64;
  localparam int LW = 32;
  localparam int N  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] addr = 8'h00;
  logic          rd_en = 1'b0;
  logic          done = 1'b0;
  logic          rdy;
  logic [DW-1:0] rd_data;
  logic          rd_data_vld;
  logic [LW-1:0] len;
  logic [N-1:0]  rdy_for_fwd = 4'b0000;
  logic [N*LW-1:0] fwd_len;
  logic [N*DW-1:0] fwd_rd_data;
  logic [N-1:0]  fwd_rd_data_vld;
  logic [AW-1:0] fwd_addr;
  logic [N-1:0]  fwd_rd_en;
  logic [N-1:0]  fwd_done;
  logic [N-1:0]  rdy_for_fwd_ack;

  logic [DW-1:0] core_data [N];
  logic [N-1:0]  core_vld;
  logic [LW-1:0] lens [N];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] exp_d;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fwd_arb dut (
    .clk(clk), .rst(rst), .addr(addr), .rd_en(rd_en), .done(done),
    .rdy(rdy), .rd_data(rd_data), .rd_data_vld(rd_data_vld), .len(len),
    .rdy_for_fwd(rdy_for_fwd), .fwd_len(fwd_len), .fwd_rd_data(fwd_rd_data),
    .fwd_rd_data_vld(fwd_rd_data_vld), .fwd_addr(fwd_addr), .fwd_rd_en(fwd_rd_en),
    .fwd_done(fwd_done), .rdy_for_fwd_ack(rdy_for_fwd_ack)
  );

  assign fwd_rd_data     = {core_data[3], core_data[2], core_data[1], core_data[0]};
  assign fwd_rd_data_vld = core_vld;
  assign fwd_len         = {lens[3], lens[2], lens[1], lens[0]};

  function automatic logic [DW-1:0] mk(input int i, input logic [AW-1:0] a);
    return 64'hD47A_0000_0000_0000 | (64'(i) << 16) | {56'h0, a};
  endfunction

  function automatic logic [LW-1:0] len_of(input int i);
    return 32'h0000_CAF0 + LW'(i);
  endfunction

  // Core model: one-cycle read latency, data tagged with core id and address.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      core_vld <= 4'b0000;
      for (int i = 0; i < N; i++) core_data[i] <= 64'h0;
    end else begin
      core_vld <= fwd_rd_en;
      for (int i = 0; i < N; i++)
        if (fwd_rd_en[i]) core_data[i] <= mk(i, fwd_addr);
    end
  end

  // Scoreboard: each returned beat must match the oldest expected read.
  always @(negedge clk) begin
    if (!rst && rd_data_vld === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_spurious: got rd_data %0h with no read outstanding", rd_data);
      end else begin
        exp_d = exp_q.pop_front();
        if (rd_data !== exp_d) begin
          errors++;
          $display("FAIL rd_data: got %0h expected %0h", rd_data, exp_d);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    tick; tick;
    checks++;
    if ({rdy, rd_data_vld, rdy_for_fwd_ack, fwd_done, fwd_rd_en} !== 14'h0) begin
      errors++;
      $display("FAIL reset_ctl: got %0h expected 0", {rdy, rd_data_vld, rdy_for_fwd_ack, fwd_done, fwd_rd_en});
    end
    checks++;
    if (len !== 32'h0) begin errors++; $display("FAIL reset_len: got %0h expected 0", len); end
    checks++;
    if (rd_data !== 64'h0) begin errors++; $display("FAIL reset_data: got %0h expected 0", rd_data); end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_single;
    rdy_for_fwd = 4'b0100;
    tick;
    checks++;
    if (rdy_for_fwd_ack !== 4'b0100 || rdy !== 1'b1) begin
      errors++; $display("FAIL single_ack: got ack=%b rdy=%b expected 0100/1", rdy_for_fwd_ack, rdy);
    end
    checks++;
    if (len !== len_of(2)) begin errors++; $display("FAIL single_len: got %0h expected %0h", len, len_of(2)); end
    rdy_for_fwd = 4'b0000;
    tick;
    checks++;
    if (rdy_for_fwd_ack !== 4'b0000) begin errors++; $display("FAIL single_ack_len: got %b expected 0000", rdy_for_fwd_ack); end
    rd_en = 1'b1; addr = 8'h10;
    exp_q.push_back(mk(2, 8'h10));
    #1;
    checks++;
    if (fwd_rd_en !== 4'b0100 || fwd_addr !== 8'h10) begin
      errors++; $display("FAIL single_rd: got en=%b addr=%h expected 0100/10", fwd_rd_en, fwd_addr);
    end
    tick;
    rd_en = 1'b0; done = 1'b1;
    tick;
    done = 1'b0;
    checks++;
    if (fwd_done !== 4'b0100 || rdy !== 1'b0) begin
      errors++; $display("FAIL single_done: got done=%b rdy=%b expected 0100/0", fwd_done, rdy);
    end
    tick;
    checks++;
    if (fwd_done !== 4'b0000) begin errors++; $display("FAIL single_done_len: got %b expected 0000", fwd_done); end
  endtask

  task automatic test_rr_wrap;
    rdy_for_fwd = 4'b0011;
    tick;
    checks++;
    if (rdy_for_fwd_ack !== 4'b0001) begin errors++; $display("FAIL rr_wrap: got %b expected 0001", rdy_for_fwd_ack); end
    rdy_for_fwd = 4'b0000; done = 1'b1;
    tick;
    done = 1'b0;
    checks++;
    if (fwd_done !== 4'b0001) begin errors++; $display("FAIL rr_wrap_done: got %b expected 0001", fwd_done); end
    rst = 1'b1;
    tick;
    rst = 1'b0;
  endtask

  task automatic test_round_robin;
    int order [5] = '{0, 1, 2, 3, 0};
    logic [N-1:0] oh;
    rdy_for_fwd = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      oh = 4'b0001 << order[k];
      tick;
      checks++;
      if (rdy_for_fwd_ack !== oh) begin errors++; $display("FAIL rr_grant%0d: got %b expected %b", k, rdy_for_fwd_ack, oh); end
      checks++;
      if (len !== len_of(order[k])) begin errors++; $display("FAIL rr_len%0d: got %0h expected %0h", k, len, len_of(order[k])); end
      rd_en = 1'b1; addr = 8'h20 + 8'(k);
      exp_q.push_back(mk(order[k], addr));
      tick;
      rd_en = 1'b0; done = 1'b1;
      tick;
      done = 1'b0;
      checks++;
      if (fwd_done !== oh) begin errors++; $display("FAIL rr_done%0d: got %b expected %b", k, fwd_done, oh); end
    end
    rdy_for_fwd = 4'b0000;
  endtask

  task automatic test_grant_hold;
    rdy_for_fwd = 4'b0010;
    tick;
    checks++;
    if (rdy_for_fwd_ack !== 4'b0010) begin errors++; $display("FAIL hold_grant: got %b expected 0010", rdy_for_fwd_ack); end
    rdy_for_fwd = 4'b1000;
    tick; tick;
    checks++;
    if (rdy_for_fwd_ack !== 4'b0000 || rdy !== 1'b1) begin
      errors++; $display("FAIL hold_ack: got ack=%b rdy=%b expected 0000/1", rdy_for_fwd_ack, rdy);
    end
    rd_en = 1'b1; addr = 8'h33;
    exp_q.push_back(mk(1, 8'h33));
    #1;
    checks++;
    if (fwd_rd_en !== 4'b0010) begin errors++; $display("FAIL hold_rd: got %b expected 0010", fwd_rd_en); end
    tick;
    rd_en = 1'b0; done = 1'b1;
    tick;
    done = 1'b0;
    checks++;
    if (fwd_done !== 4'b0010) begin errors++; $display("FAIL hold_done: got %b expected 0010", fwd_done); end
    tick;
    checks++;
    if (rdy_for_fwd_ack !== 4'b1000) begin errors++; $display("FAIL hold_next: got %b expected 1000", rdy_for_fwd_ack); end
    rdy_for_fwd = 4'b0000; done = 1'b1;
    tick;
    done = 1'b0;
    checks++;
    if (fwd_done !== 4'b1000) begin errors++; $display("FAIL hold_next_done: got %b expected 1000", fwd_done); end
  endtask

  task automatic test_ignored;
    tick;
    rd_en = 1'b1; done = 1'b1;
    #1;
    checks++;
    if (fwd_rd_en !== 4'b0000) begin errors++; $display("FAIL idle_rd: got %b expected 0000", fwd_rd_en); end
    tick;
    checks++;
    if (fwd_done !== 4'b0000 || rdy !== 1'b0) begin
      errors++; $display("FAIL idle_done: got done=%b rdy=%b expected 0000/0", fwd_done, rdy);
    end
    rd_en = 1'b0; done = 1'b0;
    tick;
    checks++;
    if (rdy_for_fwd_ack !== 4'b0000 || rdy !== 1'b0) begin
      errors++; $display("FAIL idle_state: got ack=%b rdy=%b expected 0000/0", rdy_for_fwd_ack, rdy);
    end
  endtask

  task automatic test_async_reset;
    rdy_for_fwd = 4'b0100;
    tick;
    checks++;
    if (rdy_for_fwd_ack !== 4'b0100) begin errors++; $display("FAIL areset_grant: got %b expected 0100", rdy_for_fwd_ack); end
    tick;
    rd_en = 1'b1;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({rdy, rdy_for_fwd_ack, fwd_done, fwd_rd_en} !== 13'h0 || len !== 32'h0) begin
      errors++; $display("FAIL areset_out: got ctl=%0h len=%0h expected 0/0", {rdy, rdy_for_fwd_ack, fwd_done, fwd_rd_en}, len);
    end
    rd_en = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    tick;
    checks++;
    if (rdy_for_fwd_ack !== 4'b0100 || rdy !== 1'b1) begin
      errors++; $display("FAIL areset_regrant: got ack=%b rdy=%b expected 0100/1", rdy_for_fwd_ack, rdy);
    end
    rdy_for_fwd = 4'b0000; done = 1'b1;
    tick;
    done = 1'b0;
    checks++;
    if (fwd_done !== 4'b0100) begin errors++; $display("FAIL areset_done: got %b expected 0100", fwd_done); end
  endtask

  task automatic test_pipeline;
    rdy_for_fwd = 4'b0010;
    tick;
    checks++;
    if (rdy_for_fwd_ack !== 4'b0010) begin errors++; $display("FAIL pipe_grant: got %b expected 0010", rdy_for_fwd_ack); end
    rdy_for_fwd = 4'b0000; rd_en = 1'b1; addr = 8'h55; done = 1'b1;
    exp_q.push_back(mk(1, 8'h55));
    tick;
    rd_en = 1'b0; done = 1'b0;
    checks++;
    if (fwd_done !== 4'b0010 || rdy !== 1'b0) begin
      errors++; $display("FAIL pipe_done: got done=%b rdy=%b expected 0010/0", fwd_done, rdy);
    end
`ifndef FWD_ARB_RD_PIPE_EN
    checks++;
    if (rd_data_vld !== 1'b1) begin errors++; $display("FAIL pipe_vld: got %b expected 1", rd_data_vld); end
`endif
    rdy_for_fwd = 4'b0001;
    tick;
    checks++;
    if (rdy_for_fwd_ack !== 4'b0001) begin errors++; $display("FAIL pipe_regrant: got %b expected 0001", rdy_for_fwd_ack); end
`ifdef FWD_ARB_RD_PIPE_EN
    checks++;
    if (rd_data_vld !== 1'b1) begin errors++; $display("FAIL pipe_vld: got %b expected 1", rd_data_vld); end
`endif
    rdy_for_fwd = 4'b0000; done = 1'b1;
    tick;
    done = 1'b0;
    repeat (4) tick;
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL drain: got %0d reads outstanding expected 0", exp_q.size()); end
  endtask

  initial begin
    for (int i = 0; i < N; i++) lens[i] = len_of(i);
    test_reset;
    test_single;
    test_rr_wrap;
    test_round_robin;
    test_grant_hold;
    test_ignored;
    test_async_reset;
    test_pipeline;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
